// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the pipeline requesters, the memory bus arbiter and the bus/RAM wrapper.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_re;
  logic [ADDR_W-1:0] if_addr;
  logic              if_busy;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_re;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  // Arbiter view
  modport master (
    input  if_re, if_addr, mem_re, mem_we, mem_sel, mem_addr, mem_wdata, bus_ack, bus_rdata,
    output if_busy, if_done, if_rdata, mem_busy, mem_done, mem_rdata,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
  );

  // Pipeline + bus wrapper view
  modport slave (
    output if_re, if_addr, mem_re, mem_we, mem_sel, mem_addr, mem_wdata, bus_ack, bus_rdata,
    input  if_busy, if_done, if_rdata, mem_busy, mem_done, mem_rdata,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage.
// Define ARB_RR_EN for round-robin tie breaking; default is fixed MEM-over-fetch priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master mb
);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_d, bus_we_d;
  logic [3:0]        bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d, if_rdata_d, mem_rdata_d;
  logic              if_done_d, mem_done_d, bus_err_d;
  logic              if_req, mem_req, win_mem;

  assign if_req  = mb.if_re;
  assign mem_req = mb.mem_re | mb.mem_we;

`ifdef ARB_RR_EN
  logic last_q;

  // On a tie, grant whichever requester did not win the previous grant
  assign win_mem = mem_req && (!if_req || last_q == OWN_IF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_MEM;
    end else if (state_q == IDLE && (mem_req || if_req)) begin
      last_q <= win_mem;
    end
  end
`else
  assign win_mem = mem_req;
`endif

  assign mb.if_busy  = (if_req && !(state_q == RESP && owner_q == OWN_IF)) ||
                       (state_q == GRANT && owner_q == OWN_IF);
  assign mb.mem_busy = (mem_req && !(state_q == RESP && owner_q == OWN_MEM)) ||
                       (state_q == GRANT && owner_q == OWN_MEM);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    bus_req_d   = mb.bus_req;
    bus_we_d    = mb.bus_we;
    bus_sel_d   = mb.bus_sel;
    bus_addr_d  = mb.bus_addr;
    bus_wdata_d = mb.bus_wdata;
    if_rdata_d  = mb.if_rdata;
    mem_rdata_d = mb.mem_rdata;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req || if_req) begin
          owner_d     = win_mem ? OWN_MEM : OWN_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = win_mem & mb.mem_we;
          bus_sel_d   = win_mem ? mb.mem_sel : 4'hF;
          bus_addr_d  = win_mem ? mb.mem_addr : mb.if_addr;
          bus_wdata_d = win_mem ? mb.mem_wdata : '0;
          cnt_d       = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (mb.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = mb.bus_rdata;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = mb.bus_rdata;
            if_done_d  = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort: complete the requester with zero data and flag the error
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = RESP;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = '0;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      cnt_q        <= '0;
      mb.bus_req   <= 1'b0;
      mb.bus_we    <= 1'b0;
      mb.bus_sel   <= 4'h0;
      mb.bus_addr  <= '0;
      mb.bus_wdata <= '0;
      mb.if_rdata  <= '0;
      mb.mem_rdata <= '0;
      mb.if_done   <= 1'b0;
      mb.mem_done  <= 1'b0;
      mb.bus_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mb.bus_req   <= bus_req_d;
      mb.bus_we    <= bus_we_d;
      mb.bus_sel   <= bus_sel_d;
      mb.bus_addr  <= bus_addr_d;
      mb.bus_wdata <= bus_wdata_d;
      mb.if_rdata  <= if_rdata_d;
      mb.mem_rdata <= mem_rdata_d;
      mb.if_done   <= if_done_d;
      mb.mem_done  <= mem_done_d;
      mb.bus_err   <= bus_err_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, hand-written corner sequences and random traffic.
module tb_mem_bus_arbiter;
  localparam int TMO = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .mb  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pending requests, last grant, last delivered data
  bit          m_if_p, m_mem_p, m_mem_we;
  logic [31:0] m_if_a, m_mem_a, m_mem_wd;
  logic [3:0]  m_mem_sel;
  bit          model_last;
  logic [31:0] m_if_rd, m_mem_rd;

  typedef struct {
    bit          if_re;
    logic [31:0] if_addr;
    bit          mem_re;
    bit          mem_we;
    logic [3:0]  sel;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          dly;
    logic [31:0] rd;
    bit          e_mem;
    bit          e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Winner of arbitration given pending requests (1 = MEM)
  function automatic bit pick(input bit if_p, input bit mem_p, input bit last);
`ifdef ARB_RR_EN
    if (if_p && mem_p) return !last;
`endif
    return mem_p;
  endfunction

  task automatic req_if(input logic [31:0] a);
    m_if_p = 1'b1; m_if_a = a;
    bif.if_re = 1'b1; bif.if_addr = a;
  endtask

  task automatic req_mem(input bit re, input bit we, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] wd);
    m_mem_p = 1'b1; m_mem_we = we; m_mem_sel = sel; m_mem_a = a; m_mem_wd = wd;
    bif.mem_re = re; bif.mem_we = we; bif.mem_sel = sel; bif.mem_addr = a; bif.mem_wdata = wd;
  endtask

  // Entered during an IDLE cycle with requests already driven; returns during the following IDLE cycle
  task automatic serve(input string tag, input bit w_mem, input bit e_we, input logic [3:0] e_sel,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata, input int dly,
                       input logic [31:0] rd, input bit l_pend);
    bit          acked;
    logic [31:0] e_rd;
    acked = (dly < TMO);
    e_rd  = acked ? rd : 32'h0;
    @(posedge clk); #1;
    chk({tag, " bus_req"},   32'(bif.bus_req), 32'd1);
    chk({tag, " bus_we"},    32'(bif.bus_we), 32'(e_we));
    chk({tag, " bus_sel"},   32'(bif.bus_sel), 32'(e_sel));
    chk({tag, " bus_addr"},  bif.bus_addr, e_addr);
    chk({tag, " bus_wdata"}, bif.bus_wdata, e_wdata);
    chk({tag, " win_busy"},  32'(w_mem ? bif.mem_busy : bif.if_busy), 32'd1);
    chk({tag, " lose_busy"}, 32'(w_mem ? bif.if_busy : bif.mem_busy), 32'(l_pend));
    for (int k = 0; k < TMO; k++) begin
      if (k == dly) begin
        bif.bus_ack = 1'b1; bif.bus_rdata = rd;
      end
      @(posedge clk); #1;
      bif.bus_ack = 1'b0; bif.bus_rdata = $urandom;
      if (k == dly || k == TMO - 1) break;
      chk({tag, " req_held"}, 32'(bif.bus_req), 32'd1);
    end
    chk({tag, " done"},       32'(w_mem ? bif.mem_done : bif.if_done), 32'd1);
    chk({tag, " other_done"}, 32'(w_mem ? bif.if_done : bif.mem_done), 32'd0);
    chk({tag, " bus_err"},    32'(bif.bus_err), 32'(!acked));
    chk({tag, " req_drop"},   32'(bif.bus_req), 32'd0);
    chk({tag, " rdata"},      w_mem ? bif.mem_rdata : bif.if_rdata, e_rd);
    if (w_mem) begin
      bif.mem_re = 1'b0; bif.mem_we = 1'b0;
    end else begin
      bif.if_re = 1'b0;
    end
    #1;
    chk({tag, " resp_busy"},  32'(w_mem ? bif.mem_busy : bif.if_busy), 32'd0);
    chk({tag, " resp_lbusy"}, 32'(w_mem ? bif.if_busy : bif.mem_busy), 32'(l_pend));
    @(posedge clk); #1;
    chk({tag, " done_clr"},   32'(bif.mem_done | bif.if_done | bif.bus_err), 32'd0);
    chk({tag, " rdata_hold"}, w_mem ? bif.mem_rdata : bif.if_rdata, e_rd);
    model_last = w_mem;
    if (w_mem) m_mem_rd = e_rd; else m_if_rd = e_rd;
  endtask

  task automatic serve_next(input string tag, input int dly);
    bit w;
    w = pick(m_if_p, m_mem_p, model_last);
    if (w) begin
      serve(tag, 1'b1, m_mem_we, m_mem_sel, m_mem_a, m_mem_wd, dly, $urandom, m_if_p);
      m_mem_p = 1'b0;
    end else begin
      serve(tag, 1'b0, 1'b0, 4'hF, m_if_a, 32'h0, dly, $urandom, m_mem_p);
      m_if_p = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs[6];
    n_tests = 0; n_fail = 0;
    m_if_p = 0; m_mem_p = 0; m_mem_we = 0; m_if_a = 0; m_mem_a = 0; m_mem_wd = 0; m_mem_sel = 0;
    model_last = 1'b1; m_if_rd = 0; m_mem_rd = 0;
    bif.if_re = 0; bif.if_addr = 0; bif.mem_re = 0; bif.mem_we = 0; bif.mem_sel = 0;
    bif.mem_addr = 0; bif.mem_wdata = 0; bif.bus_ack = 0; bif.bus_rdata = 0;

    vecs[0] = '{0, 0, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 2, 32'h5555, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF};
    vecs[1] = '{1, 32'h40, 0, 0, 4'h0, 0, 0, 0, 32'h13, 0, 0, 4'hF, 32'h40, 32'h0};
    vecs[2] = '{0, 0, 1, 1, 4'h3, 32'h200, 32'h12345678, 1, 32'h77, 1, 1, 4'h3, 32'h200, 32'h12345678};
    vecs[3] = '{0, 0, 1, 0, 4'h1, 32'h300, 32'hCAFE, TMO - 1, 32'hA5A5, 1, 0, 4'h1, 32'h300, 32'hCAFE};
    vecs[4] = '{0, 0, 0, 1, 4'hC, 32'h400, 32'h99, 99, 32'h1234, 1, 1, 4'hC, 32'h400, 32'h99};
    vecs[5] = '{1, 32'h500, 0, 0, 4'h0, 0, 0, TMO, 32'h4321, 0, 0, 4'hF, 32'h500, 32'h0};

    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst bus_req",   32'(bif.bus_req), 32'd0);
    chk("rst bus_we",    32'(bif.bus_we), 32'd0);
    chk("rst bus_sel",   32'(bif.bus_sel), 32'd0);
    chk("rst bus_addr",  bif.bus_addr, 32'd0);
    chk("rst bus_wdata", bif.bus_wdata, 32'd0);
    chk("rst dones",     32'({bif.if_done, bif.mem_done, bif.bus_err}), 32'd0);
    chk("rst if_rdata",  bif.if_rdata, 32'd0);
    chk("rst mem_rdata", bif.mem_rdata, 32'd0);
    chk("rst busy",      32'({bif.if_busy, bif.mem_busy}), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single-requester vectors
    for (int i = 0; i < 6; i++) begin
      bif.if_re = vecs[i].if_re; bif.if_addr = vecs[i].if_addr;
      bif.mem_re = vecs[i].mem_re; bif.mem_we = vecs[i].mem_we; bif.mem_sel = vecs[i].sel;
      bif.mem_addr = vecs[i].maddr; bif.mem_wdata = vecs[i].mwdata;
      serve($sformatf("vec%0d", i), vecs[i].e_mem, vecs[i].e_we, vecs[i].e_sel, vecs[i].e_addr,
            vecs[i].e_wdata, vecs[i].dly, vecs[i].rd, 1'b0);
    end

    // Simultaneous requests: repeated ties, then drain both
    req_if(32'h80);
    req_mem(1'b1, 1'b0, 4'h3, 32'h900, 32'h0);
    for (int r = 0; r < 4; r++) begin
      bit w;
      w = pick(1'b1, 1'b1, model_last);
      serve_next("tie", 1);
      if (w) req_mem(1'b1, 1'b0, 4'h3, 32'h900, 32'h0); else req_if(32'h80);
    end
    serve_next("drain_a", 0);
    serve_next("drain_b", 0);

    // Stray ack while idle must do nothing
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bif.bus_ack = 1'b0;
    chk("idle_ack dones",  32'({bif.if_done, bif.mem_done, bif.bus_err}), 32'd0);
    chk("idle_ack req",    32'(bif.bus_req), 32'd0);
    chk("idle_ack if_rd",  bif.if_rdata, m_if_rd);
    chk("idle_ack mem_rd", bif.mem_rdata, m_mem_rd);
    req_if(32'h60);
    serve_next("after_idle_ack", 0);

    // Reset while a fetch holds the bus
    req_if(32'h44);
    @(posedge clk); #1;
    chk("mid_rst pre_req", 32'(bif.bus_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst req_drop", 32'(bif.bus_req), 32'd0);
    chk("mid_rst if_rdata", bif.if_rdata, 32'd0);
    bif.if_re = 1'b0; m_if_p = 1'b0; model_last = 1'b1; m_if_rd = 0; m_mem_rd = 0;
    @(posedge clk); #1;
    chk("mid_rst no_done", 32'({bif.if_done, bif.mem_done, bif.bus_err}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    req_if(32'h48);
    serve_next("post_rst", 0);

    // Random traffic against the model
    for (int t = 0; t < 60; t++) begin
      int kind;
      if (!m_if_p && $urandom_range(0, 1) == 1) req_if($urandom);
      if (!m_mem_p && (!m_if_p || $urandom_range(0, 1) == 1)) begin
        kind = $urandom_range(0, 2);
        req_mem(kind != 1, kind != 0, 4'($urandom), $urandom, $urandom);
      end
      serve_next("rand", $urandom_range(0, 9));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
